// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO, WIDTH x DEPTH, with occupancy count,
// almost-full/almost-empty thresholds and defined rd+wr behaviour at full
// and empty.
//
// Ports:
//   clock, rst_n         rising-edge clock, async active-low reset
//   wr, data_in          write request and data
//   rd, data_out         read request, registered read data
//   full, empty          count == DEPTH / count == 0
//   almost_full          count >= AF_LEVEL
//   almost_empty         count <= AE_LEVEL
//   count                occupancy 0..DEPTH
//   err_clr              clears sticky error flags
//   overflow, underflow  sticky write-dropped / read-on-empty flags
//
// Optional feature: define FIFO_ERR_FLAGS_EN to build the sticky error
// flags; otherwise they are tied low and err_clr is ignored.

module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // A write while full only lands if a read frees a slot this cycle.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  // Storage has no reset; empty gates every read of stale contents.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      unique case (1'b1)
        wr_acc & ~rd_acc: count <= count + CW'(1);
        rd_acc & ~wr_acc: count <= count - CW'(1);
        default:          count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Set has priority over clear when both happen in one cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr & ~wr_acc) overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (rd & empty)    underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed bench for fifo_sync_param at
// WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.

module tb_fifo_sync_param;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       wr;
  logic [7:0] data_in;
  logic       rd;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       err_clr;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  fifo_sync_param #(
    .WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .wr           (wr),
    .data_in      (data_in),
    .rd           (rd),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    data_in = 8'h00;
    err_clr = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_dout", 32'(data_out), 32'h00);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Fill 0x10..0x17, thresholds checked at every count.
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1;
      data_in = 8'(8'h10 + i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 6));
      chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= 2));
      chk("fill_full", 32'(full), 32'(i == 7));
      chk("fill_empty", 32'(empty), 32'd0);
    end

    // Write while full, no read: dropped.
    data_in = 8'hEE;
    tick();
    wr = 1'b0;
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'(ERR_EN));
    chk("ovf_dout", 32'(data_out), 32'h00);

    // Drain: data unchanged by the dropped write.
    for (int i = 0; i < 8; i++) begin
      rd = 1'b1;
      tick();
      chk("drain_dout", 32'(data_out), 32'(8'h10 + i));
      chk("drain_count", 32'(count), 32'(7 - i));
      chk("drain_empty", 32'(empty), 32'(i == 7));
      chk("drain_ae", 32'(almost_empty), 32'((7 - i) <= 2));
      chk("drain_af", 32'(almost_full), 32'((7 - i) >= 6));
    end

    // Read while empty.
    tick();
    rd = 1'b0;
    chk("udf_flag", 32'(underflow), 32'(ERR_EN));
    chk("udf_dout", 32'(data_out), 32'h17);
    chk("udf_count", 32'(count), 32'd0);

    // Set wins over clear for underflow; overflow clears.
    rd = 1'b1;
    err_clr = 1'b1;
    tick();
    rd = 1'b0;
    chk("setwin_udf", 32'(underflow), 32'(ERR_EN));
    chk("setwin_ovf", 32'(overflow), 32'd0);
    tick();
    err_clr = 1'b0;
    chk("clr_udf", 32'(underflow), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // rd & wr on empty: write only, no bypass.
    rd = 1'b1;
    wr = 1'b1;
    data_in = 8'h55;
    tick();
    rd = 1'b0;
    wr = 1'b0;
    chk("emp_rw_count", 32'(count), 32'd1);
    chk("emp_rw_dout", 32'(data_out), 32'h17);
    chk("emp_rw_udf", 32'(underflow), 32'(ERR_EN));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("emp_rw_clr", 32'(underflow), 32'd0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("emp_rw_read", 32'(data_out), 32'h55);
    chk("emp_rw_empty", 32'(empty), 32'd1);

    // Wrap-around: hold 3 entries over 20 rd/wr pairs.
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1;
      data_in = 8'(8'hA0 + i);
      tick();
    end
    chk("wrap_pre", 32'(count), 32'd3);
    for (int i = 0; i < 20; i++) begin
      wr = 1'b1;
      rd = 1'b1;
      data_in = 8'(i);
      tick();
      chk("wrap_dout", 32'(data_out),
          (i < 3) ? 32'(8'hA0 + i) : 32'(i - 3));
      chk("wrap_count", 32'(count), 32'd3);
    end
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1;
      tick();
      chk("wrap_tail", 32'(data_out), 32'(8'h11 + i));
    end
    rd = 1'b0;
    chk("wrap_empty", 32'(empty), 32'd1);

    // rd & wr on full: both accepted, count stays 8.
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1;
      data_in = 8'(8'h30 + i);
      tick();
    end
    rd = 1'b1;
    data_in = 8'hAA;
    tick();
    wr = 1'b0;
    chk("full_rw_dout", 32'(data_out), 32'h30);
    chk("full_rw_count", 32'(count), 32'd8);
    chk("full_rw_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("full_rw_drain", 32'(data_out),
          (i == 7) ? 32'hAA : 32'(8'h31 + i));
    end
    rd = 1'b0;
    chk("full_rw_empty", 32'(empty), 32'd1);

    // Async reset mid-stream with count=5.
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1;
      data_in = 8'(8'h60 + i);
      tick();
    end
    wr = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_dout", 32'(data_out), 32'h00);
    chk("arst_ae", 32'(almost_empty), 32'd1);
    #10 rst_n = 1'b1;
    tick();
    wr = 1'b1;
    data_in = 8'h77;
    tick();
    wr = 1'b0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("post_rst_dout", 32'(data_out), 32'h77);
    chk("post_rst_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO that supersedes the fixed 8-bit x 32 buffer. It generalises data width and depth, uses the full configured depth, and adds an occupancy count, programmable almost-full/almost-empty thresholds, and defined simultaneous read/write behaviour at full and empty. It sits between a producer and a consumer in the same clock domain, for example command queues and byte/word staging ahead of serial or bus interfaces.

## Interface
- WIDTH, 8, data word width in bits (>= 1)
- DEPTH, 32, number of entries; power of two, >= 4
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
- Derived: AW = log2(DEPTH), CW = AW+1

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wr  in  1  write request
- data_in  in  WIDTH  write data, sampled with wr
- rd  in  1  read request
- data_out  out  WIDTH  registered read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  CW  current occupancy, 0..DEPTH
- err_clr  in  1  clears sticky error flags (FIFO_ERR_FLAGS_EN only)
- overflow  out  1  sticky: write dropped
- underflow  out  1  sticky: read on empty

## Operation
- Storage: DEPTH x WIDTH array, not reset. Write and read pointers are AW bits wide and wrap modulo DEPTH. count is a CW-bit register.
- rd_acc = rd & ~empty.
- wr_acc = wr & (~full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] <= data_in and wr_ptr increments.
- On rd_acc: data_out <= mem[rd_ptr] and rd_ptr increments. Otherwise data_out holds its value.
- count next value:
  - +1 on wr_acc & ~rd_acc
  - -1 on rd_acc & ~wr_acc
  - unchanged otherwise
- rd & wr while empty: the write is accepted and the read is rejected. There is no bypass. count goes from 0 to 1.
- rd & wr while full: both are accepted. count stays DEPTH. The new word is written into the slot freed by the read.
- A rejected request has no effect on the pointers, memory or data_out.
- full, empty, almost_full and almost_empty are combinational decodes of the count register only.
- Reset (rst_n low, asynchronous assert, synchronous deassert handled upstream) forces:
  - pointers = 0, count = 0, data_out = 0, overflow = 0, underflow = 0
  - hence empty = 1, full = 0, almost_empty = 1, almost_full = 0
- Reset mid-operation discards all contents. Memory contents are don't-care afterwards and are never visible, because empty blocks reads.

## Timing
- Write-to-read latency: a word written at edge N is readable from edge N+1. empty deasserts after edge N.
- Read latency: data_out is valid immediately after the edge where rd_acc was high (1 cycle from the rd request).
- Flags and count change only after a clock edge and are stable for the whole cycle.
- Throughput: one write and one read per cycle, sustained.
- Ordering: strict FIFO. Pointer wrap-around is transparent.

## Configuration
- FIFO_ERR_FLAGS_EN defined:
  - overflow sets on wr & ~wr_acc.
  - underflow sets on rd & empty.
  - Both flags hold until err_clr = 1 at a clock edge. If a set condition and err_clr occur in the same cycle, set wins.
- FIFO_ERR_FLAGS_EN undefined:
  - overflow and underflow are tied to 0.
  - err_clr is ignored.
  - The error logic is absent from the netlist.

## Test plan
All scenarios use WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
- Reset check: assert rst_n=0 mid-stream with count=5, then release.
  - Required response: count=0, empty=1, data_out=0x00 immediately, without waiting for a clock edge.
- Fill and drain: write 0x10..0x17.
  - Required response after the 8th write: full=1, count=8, almost_full=1 (from count=6).
  - Then read 8 times: data_out sequence 0x10..0x17, one per cycle. empty=1 after the last read.
- Wrap-around: perform 20 interleaved write/read pairs with data 0x00..0x13, with the FIFO holding 3 entries throughout.
  - Required response: output order is preserved across the pointer wrap, and count stays 3.
- Simultaneous access:
  - Full with rd=wr=1 and data_in=0xAA: count stays 8, and 0xAA is read out 8 reads later.
  - Empty with rd=wr=1 and data_in=0x55: count=1, data_out unchanged.
- Thresholds: step count through 0..8.
  - almost_empty=1 for counts 0..2.
  - almost_full=1 for counts 6..8.
- Errors (FIFO_ERR_FLAGS_EN):
  - wr=1 while full with rd=0: overflow=1, and the stored data is unchanged.
  - rd=1 while empty: underflow=1.
  - err_clr=1 clears both flags on the next edge.
